// File: rtl/filter_output_packer_if.sv
// Word stream from the pixel packer to a DMA/bus writer.
// The packer drives word/keep/last/valid; the writer drives ready.
interface filter_output_packer_if;
    logic [31:0] word_o;
    logic [3:0]  keep_o;
    logic        last_o;
    logic        valid_o;
    logic        ready_i;

    modport master (
        output word_o,
        output keep_o,
        output last_o,
        output valid_o,
        input  ready_i
    );

    modport slave (
        input  word_o,
        input  keep_o,
        input  last_o,
        input  valid_o,
        output ready_i
    );
endinterface

// File: rtl/filter_output_packer.sv
// Packs the 3x3 filter's 8-bit pixel stream into 32-bit words.
// A completed word is held back until the next pixel or the frame end,
// so that the last flag is known when the word enters the output FIFO.
// The input side has no backpressure; a full FIFO drops words and
// raises a sticky overflow flag.
module filter_output_packer #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               data_i,
    input  logic                     valid_i,
    input  logic                     frame_i,
    filter_output_packer_if.master   out_bus,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic        frame_prev;
    logic [2:0]  cnt;
    logic [31:0] acc;
    logic [4:0]  lane_lsb;

    logic        accept;
    logic        frame_end;
    logic        push;
    logic        push_last;
    logic [3:0]  push_keep;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          pop;
    logic          write_en;
    logic [36:0]   mem [DEPTH];
    logic [36:0]   head;

    assign accept    = valid_i && frame_i;
    assign frame_end = frame_prev && !frame_i;
    assign lane_lsb  = {cnt[1:0], 3'b000};

    // A full accumulator is flushed by the next pixel; any content is flushed at frame end.
    assign push      = (accept && (cnt == 3'd4)) || (frame_end && (cnt != 3'd0));
    assign push_last = frame_end;

    // Byte enables of the word being pushed follow the number of filled lanes.
    always_comb begin
        push_keep = 4'h0;
        case (cnt)
            3'd1:    push_keep = 4'h1;
            3'd2:    push_keep = 4'h3;
            3'd3:    push_keep = 4'h7;
            3'd4:    push_keep = 4'hF;
            default: push_keep = 4'h0;
        endcase
    end

    // Accumulator and frame edge tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_prev <= 1'b0;
            cnt        <= 3'd0;
            acc        <= 32'd0;
        end else begin
            frame_prev <= frame_i;
            if (accept) begin
                if (cnt == 3'd4) begin
                    acc <= {24'd0, data_i};
                    cnt <= 3'd1;
                end else begin
                    acc[lane_lsb +: 8] <= data_i;
                    cnt                <= cnt + 3'd1;
                end
            end else if (frame_end) begin
                acc <= 32'd0;
                cnt <= 3'd0;
            end
        end
    end

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign pop      = !empty && out_bus.ready_i;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign write_en = push && (!full || pop);

    // FIFO storage; contents are only observable through the empty-gated head.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[wr_ptr[AW-1:0]] <= {push_last, push_keep, acc};
        end
    end

    // Pointers and sticky overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && full && !pop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    assign head    = mem[rd_ptr[AW-1:0]];
    assign level_o = wr_ptr - rd_ptr;

    // Head outputs read zero while the FIFO is empty.
    always_comb begin
        out_bus.valid_o = !empty;
        out_bus.word_o  = 32'd0;
        out_bus.keep_o  = 4'h0;
        out_bus.last_o  = 1'b0;
        if (!empty) begin
            out_bus.word_o = head[31:0];
            out_bus.keep_o = head[35:32];
            out_bus.last_o = head[36];
        end
    end
endmodule

// File: doc/filter_output_packer.md
# filter_output_packer

Downstream stage of the 3x3 image filter. Consumes the filter's 8-bit pixel stream (data/valid/frame) and packs four consecutive pixels into 32-bit words. Words are queued in a FIFO with ready/valid backpressure for a DMA/bus writer. The frame end is marked with `last_o`, and a trailing partial word carries byte enables.

## Interface
Parameters:
- DEPTH, 16, FIFO depth in 32-bit words; power of 2, ≥ 2.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- data_i  in  8  pixel from filter output.
- valid_i  in  1  pixel qualifier.
- frame_i  in  1  frame active level; high for the whole frame.
- word_o  out  32  packed word; first pixel of the word in [7:0], fourth in [31:24].
- keep_o  out  4  byte enables for word_o; bit n covers byte n.
- last_o  out  1  word is the final word of the frame.
- valid_o  out  1  FIFO head valid (FIFO not empty).
- ready_i  in  1  consumer accepts the head word on an edge where valid_o && ready_i.
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow_o  out  1  sticky flag: a word was dropped because the FIFO was full.

## Operation
- The filter has no backpressure. The input side never stalls.
- A pixel is accepted on an edge where valid_i && frame_i. A pixel with frame_i low is ignored.
- frame_prev register holds frame_i from the previous edge. A frame end is an edge where frame_prev=1 and frame_i=0.
- Accumulator: acc[31:0] plus cnt (0..4). A completed word is held until the next pixel or the frame end, so `last` is known when the word is pushed.
  - Pixel with cnt<4: write byte lane cnt, then cnt+1.
  - Pixel with cnt==4: push {acc, keep=4'hF, last=0}; acc cleared, new byte in lane 0, cnt=1.
  - Frame end with cnt>0: push {acc, keep=(1<<cnt)-1, last=1}; cnt=0, acc=0.
  - Frame end with cnt==0 (empty frame): no push.
- Unused byte lanes of a partial word are 0.
- FIFO storage is circular, DEPTH entries of {word, keep, last}. Read and write pointers are ($clog2(DEPTH)+1) bits and wrap naturally.
  - Full: pointers differ only in the MSB.
  - Empty: pointers are equal.
- Push with FIFO full and no pop on the same edge: the word is dropped and overflow_o is set. overflow_o stays set until reset.
- Push and pop on the same edge: both take effect. This is also true when full, so no drop occurs; level_o is unchanged.
- Pop on an edge where FIFO is empty: impossible by construction, since valid_o=0.

## Timing
- Reset values: valid_o=0, word_o=0, keep_o=0, last_o=0, level_o=0, overflow_o=0, cnt=0, acc=0, frame_prev=0, pointers=0.
- Reset mid-frame: partial acc and all queued words are discarded.
  - After release, pixels pack from lane 0.
  - If frame_i is already high at release, the frame end is still detected when frame_i falls.
- Push occurs at the edge that samples the trigger (5th pixel or frame end). From that edge, the word is visible at the FIFO head: valid_o, word_o, keep_o and last_o are updated if the FIFO was empty.
- Latency from the frame_i falling-sample edge to last_o visible: 0 cycles (same edge) when the FIFO was empty.
- word_o, keep_o and last_o are stable while valid_o=1 and ready_i=0.
- level_o is registered and updated on every push/pop edge.
- Throughput: one pop per cycle; input at most one pixel per cycle, i.e. ≤ 1 word per 4 cycles.

## Test plan
- Frame of 8 pixels 0x01..0x08, ready_i=1 → two words, in order:
  - 0x04030201, keep 0xF, last 0 (pushed on the 5th pixel);
  - 0x08070605, keep 0xF, last 1 (pushed at the frame end).
- Frame of 6 pixels 0x10..0x15 → two words, in order:
  - 0x13121110, keep 0xF, last 0;
  - 0x00001514, keep 0x3, last 1.
- Same 8-pixel frame with random valid_i gaps, plus pixels driven while frame_i=0 → output identical to scenario 1; ignored pixels never appear.
- ready_i=0, produce DEPTH+2 words (4*(DEPTH+2) pixels, one frame) → level_o=DEPTH and overflow_o=1. Then raise ready_i → the first DEPTH words drain in order; overflow_o stays 1.
- frame_i high for 10 cycles with valid_i=0 → no word pushed; level_o stays 0.
- Reset pulled low with 3 bytes accumulated and 2 words queued → valid_o=0, level_o=0. The next frame of 4 pixels 0xA0..0xA3 yields 0xA3A2A1A0, keep 0xF, last 1.
